// File: rtl/dm_run_ctl_if.sv
// Debug handshake between the run-control sequencer and the hart's debug interface.
// The master side requests halt/resume; the slave (core) reports halted and reset status.
interface dm_run_ctl_if;
    logic halt_req;
    logic resume_req;
    logic hart_halted;
    logic hart_reset;

    modport master (output halt_req, resume_req, input hart_halted, hart_reset);
    modport slave  (input halt_req, resume_req, output hart_halted, hart_reset);
endinterface

// File: rtl/dm_run_ctl.sv
// Debug Module run-control sequencer for a single hart: turns DMCONTROL halt/resume
// requests into a halt_req/resume_req handshake and publishes registered DMSTATUS bits.
module dm_run_ctl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dm_active,
    input  logic                dm_haltreq,
    input  logic                dm_resumereq,
    input  logic                dm_ackhavereset,
    input  logic                timeout_clr,
    dm_run_ctl_if.master        dbg,
    output logic                st_halted,
    output logic                st_running,
    output logic                st_resumeack,
    output logic                st_havereset,
    output logic                busy,
    output logic                timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        RUNNING  = 2'd0,
        HALTING  = 2'd1,
        HALTED   = 2'd2,
        RESUMING = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          to_hit;
    logic          resumeack_next;

    // hart_reset overrides every transition; the counter only advances while a handshake stays pending.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        to_hit         = 1'b0;
        resumeack_next = st_resumeack;
        if (dbg.hart_reset) begin
            state_next     = RUNNING;
            cnt_next       = '0;
            resumeack_next = 1'b0;
        end else begin
            case (state)
                RUNNING: begin
                    if (dbg.hart_halted) begin
                        state_next = HALTED;
                    end else if (dm_haltreq) begin
                        state_next = HALTING;
                        cnt_next   = '0;
                    end
                end
                HALTING: begin
                    if (dbg.hart_halted) begin
                        state_next = HALTED;
                    end else if (cnt != CNT_MAX) begin
                        cnt_next = cnt + 1'b1;
                        to_hit   = (cnt_next == CNT_MAX);
                    end
                end
                HALTED: begin
                    if (dm_resumereq && !dm_haltreq) begin
                        state_next     = RESUMING;
                        cnt_next       = '0;
                        resumeack_next = 1'b0;
                    end else if (!dbg.hart_halted) begin
                        state_next = RUNNING;
                    end
                end
                RESUMING: begin
                    if (!dbg.hart_halted) begin
                        state_next     = RUNNING;
                        resumeack_next = 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt_next = cnt + 1'b1;
                        to_hit   = (cnt_next == CNT_MAX);
                    end
                end
                default: state_next = RUNNING;
            endcase
        end
    end

    // Status outputs are registered from the next state so they never glitch toward the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUNNING;
            cnt            <= '0;
            dbg.halt_req   <= 1'b0;
            dbg.resume_req <= 1'b0;
            st_running     <= 1'b1;
            st_halted      <= 1'b0;
            st_resumeack   <= 1'b0;
            st_havereset   <= 1'b1;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
        end else if (!dm_active) begin
            state          <= RUNNING;
            cnt            <= '0;
            dbg.halt_req   <= 1'b0;
            dbg.resume_req <= 1'b0;
            st_running     <= 1'b1;
            st_halted      <= 1'b0;
            st_resumeack   <= 1'b0;
            st_havereset   <= 1'b1;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            dbg.halt_req   <= (state_next == HALTING);
            dbg.resume_req <= (state_next == RESUMING);
            st_running     <= (state_next == RUNNING);
            st_halted      <= (state_next == HALTED);
            busy           <= (state_next == HALTING) || (state_next == RESUMING);
            st_resumeack   <= resumeack_next;
            st_havereset   <= dbg.hart_reset | (st_havereset & ~dm_ackhavereset);
            timeout_err    <= to_hit | (timeout_err & ~timeout_clr);
        end
    end

endmodule

// File: tb/tb_dm_run_ctl.sv
// Bench for dm_run_ctl: directed handshake scenarios then random traffic, with every
// cycle compared against a behavioural model of the hart's run/halt status.
module tb_dm_run_ctl;

    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst_n, dm_active, dm_haltreq, dm_resumereq, dm_ackhavereset, timeout_clr;
    logic hart_reset, hart_halted;
    logic st_halted, st_running, st_resumeack, st_havereset, busy, timeout_err;

    int n_vec = 0;
    int n_err = 0;

    // Model: halted flag, pending request (0 none, 1 halt, 2 resume), cycles waited.
    bit m_halted, m_rack, m_hrst, m_to;
    int m_pend, m_wait;

    dm_run_ctl_if dbg();
    assign dbg.hart_halted = hart_halted;
    assign dbg.hart_reset  = hart_reset;

    dm_run_ctl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .dm_active(dm_active), .dm_haltreq(dm_haltreq),
        .dm_resumereq(dm_resumereq), .dm_ackhavereset(dm_ackhavereset),
        .timeout_clr(timeout_clr), .dbg(dbg), .st_halted(st_halted),
        .st_running(st_running), .st_resumeack(st_resumeack),
        .st_havereset(st_havereset), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_halted = 0; m_pend = 0; m_wait = 0; m_rack = 0; m_hrst = 1; m_to = 0;
    endtask

    task automatic model_edge();
        bit fire;
        fire = 0;
        if (!rst_n || !dm_active) begin
            model_reset();
        end else if (hart_reset) begin
            m_halted = 0; m_pend = 0; m_wait = 0; m_rack = 0; m_hrst = 1;
            m_to = m_to & !timeout_clr;
        end else begin
            if (dm_ackhavereset) m_hrst = 0;
            if (m_pend == 1) begin
                if (hart_halted) begin m_pend = 0; m_halted = 1; end
                else begin m_wait++; fire = (m_wait == TO); end
            end else if (m_pend == 2) begin
                if (!hart_halted) begin m_pend = 0; m_halted = 0; m_rack = 1; end
                else begin m_wait++; fire = (m_wait == TO); end
            end else if (!m_halted) begin
                if (hart_halted) m_halted = 1;
                else if (dm_haltreq) begin m_pend = 1; m_wait = 0; end
            end else begin
                if (dm_resumereq && !dm_haltreq) begin m_pend = 2; m_wait = 0; m_rack = 0; end
                else if (!hart_halted) m_halted = 0;
            end
            m_to = fire | (m_to & !timeout_clr);
        end
    endtask

    task automatic check_output(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check_output("halt_req",     dbg.halt_req,   m_pend == 1);
        check_output("resume_req",   dbg.resume_req, m_pend == 2);
        check_output("st_halted",    st_halted,      m_halted && m_pend == 0);
        check_output("st_running",   st_running,     !m_halted && m_pend == 0);
        check_output("busy",         busy,           m_pend != 0);
        check_output("st_resumeack", st_resumeack,   m_rack);
        check_output("st_havereset", st_havereset,   m_hrst);
        check_output("timeout_err",  timeout_err,    m_to);
    endtask

    // One clock: model consumes current inputs, then outputs are sampled 1ns after the edge.
    task automatic apply_stimulus();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n = 0; dm_active = 1; dm_haltreq = 0; dm_resumereq = 0; dm_ackhavereset = 0;
        timeout_clr = 0; hart_reset = 0; hart_halted = 0;
        model_reset();
        #12;
        check_outputs();
        check_output("rst_running", st_running, 1'b1);
        check_output("rst_havereset", st_havereset, 1'b1);
        @(negedge clk) rst_n = 1;
        apply_stimulus();
        apply_stimulus();

        // Halt handshake
        dm_haltreq = 1;
        apply_stimulus();
        check_output("halt_req_on", dbg.halt_req, 1'b1);
        check_output("halt_busy", busy, 1'b1);
        apply_stimulus();
        apply_stimulus();
        hart_halted = 1;
        apply_stimulus();
        dm_haltreq = 0;
        check_output("halt_done_halted", st_halted, 1'b1);
        check_output("halt_done_req", dbg.halt_req, 1'b0);
        check_output("halt_done_busy", busy, 1'b0);

        // Resume handshake
        dm_resumereq = 1;
        apply_stimulus();
        dm_resumereq = 0;
        check_output("resume_req_on", dbg.resume_req, 1'b1);
        check_output("resume_ack_clr", st_resumeack, 1'b0);
        apply_stimulus();
        apply_stimulus();
        hart_halted = 0;
        apply_stimulus();
        check_output("resume_ack_set", st_resumeack, 1'b1);
        check_output("resume_running", st_running, 1'b1);

        // Spontaneous halt, then resume ignored while haltreq is high
        hart_halted = 1;
        apply_stimulus();
        check_output("spont_halted", st_halted, 1'b1);
        check_output("spont_no_req", dbg.halt_req, 1'b0);
        dm_haltreq = 1; dm_resumereq = 1;
        apply_stimulus();
        dm_resumereq = 0; dm_haltreq = 0;
        check_output("ign_halted", st_halted, 1'b1);
        check_output("ign_resume_req", dbg.resume_req, 1'b0);
        check_output("ign_ack_kept", st_resumeack, 1'b1);

        // Havereset acknowledge and set-wins collision
        dm_ackhavereset = 1;
        apply_stimulus();
        check_output("ack_clears", st_havereset, 1'b0);
        hart_reset = 1;
        apply_stimulus();
        dm_ackhavereset = 0; hart_reset = 0; hart_halted = 0;
        check_output("ack_vs_reset", st_havereset, 1'b1);
        apply_stimulus();

        // hart_reset aborts a pending halt; the held haltreq re-enters HALTING
        dm_haltreq = 1;
        apply_stimulus();
        hart_reset = 1;
        apply_stimulus();
        hart_reset = 0;
        check_output("hreset_abort_req", dbg.halt_req, 1'b0);
        check_output("hreset_running", st_running, 1'b1);
        apply_stimulus();

        // Timeout while HALTING, clear, stays clear while saturated
        apply_stimulus();
        apply_stimulus();
        apply_stimulus();
        check_output("to_not_yet", timeout_err, 1'b0);
        apply_stimulus();
        check_output("to_set", timeout_err, 1'b1);
        check_output("to_req_held", dbg.halt_req, 1'b1);
        timeout_clr = 1;
        apply_stimulus();
        timeout_clr = 0;
        check_output("to_cleared", timeout_err, 1'b0);
        apply_stimulus();
        apply_stimulus();
        check_output("to_no_reset", timeout_err, 1'b0);
        hart_halted = 1; dm_haltreq = 0;
        apply_stimulus();
        dm_resumereq = 1;
        apply_stimulus();
        dm_resumereq = 0; hart_halted = 0;
        apply_stimulus();
        dm_haltreq = 1;
        apply_stimulus();
        apply_stimulus();
        apply_stimulus();
        apply_stimulus();
        check_output("to2_not_yet", timeout_err, 1'b0);
        timeout_clr = 1;
        apply_stimulus();
        timeout_clr = 0;
        check_output("to2_set_wins", timeout_err, 1'b1);
        hart_halted = 1; dm_haltreq = 0;
        apply_stimulus();

        // haltreq during RESUMING is deferred until RUNNING
        dm_resumereq = 1;
        apply_stimulus();
        dm_resumereq = 0; dm_haltreq = 1;
        apply_stimulus();
        check_output("defer_resume_req", dbg.resume_req, 1'b1);
        check_output("defer_no_halt", dbg.halt_req, 1'b0);
        hart_halted = 0;
        apply_stimulus();
        check_output("defer_running", st_running, 1'b1);
        apply_stimulus();
        check_output("defer_halting", dbg.halt_req, 1'b1);
        hart_halted = 1; dm_haltreq = 0;
        apply_stimulus();

        // Asynchronous reset in the middle of a resume
        dm_resumereq = 1;
        apply_stimulus();
        dm_resumereq = 0;
        check_output("pre_rst_resume", dbg.resume_req, 1'b1);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_output("async_rst_resume", dbg.resume_req, 1'b0);
        check_outputs();
        @(negedge clk) rst_n = 1;
        hart_halted = 1;
        apply_stimulus();

        // dm_active low clears block state
        dm_active = 0;
        apply_stimulus();
        check_output("dmact_running", st_running, 1'b1);
        check_output("dmact_havereset", st_havereset, 1'b1);
        dm_active = 1; hart_halted = 0;
        apply_stimulus();

        // Random traffic with a loosely cooperative core
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) dm_haltreq = ~dm_haltreq;
            dm_resumereq    = ($urandom_range(5) == 0);
            dm_ackhavereset = ($urandom_range(9) == 0);
            timeout_clr     = ($urandom_range(7) == 0);
            hart_reset      = ($urandom_range(39) == 0);
            dm_active       = ($urandom_range(59) != 0);
            if (m_pend == 1 && $urandom_range(2) == 0) hart_halted = 1;
            else if (m_pend == 2 && $urandom_range(2) == 0) hart_halted = 0;
            else if ($urandom_range(24) == 0) hart_halted = ~hart_halted;
            apply_stimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dm_run_ctl.md
Name: dm_run_ctl

Overview:
Run-control sequencer in the Debug Module for a single hart. It turns DMCONTROL haltreq/resumereq/ackhavereset into a clean halt_req/resume_req handshake toward the core's debug interface, and waits for the core's halted indication. It exposes registered status (halted, running, resumeack, havereset, busy, timeout) for DMSTATUS and abstract-command gating.

Parameters:
TIMEOUT_CYCLES, 1024, cycles a halt or resume handshake may stay pending before timeout_err sets (must be ≥1).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
dm_active  in  1  DMCONTROL.dmactive; 0 clears block state synchronously, same values as reset
dm_haltreq  in  1  level, DMCONTROL.haltreq
dm_resumereq  in  1  one-cycle pulse, DMCONTROL write with resumereq=1
dm_ackhavereset  in  1  one-cycle pulse, clears havereset
timeout_clr  in  1  one-cycle pulse, clears timeout_err
hart_reset  in  1  core is in reset (level)
hart_halted  in  1  core halted indication (debug_if.halted)
halt_req  out  1  to core debug_if.halt_req
resume_req  out  1  to core debug_if.resume_req
st_halted  out  1  hart halted (state HALTED)
st_running  out  1  hart running (state RUNNING)
st_resumeack  out  1  last resume request completed
st_havereset  out  1  hart reset since last ack
busy  out  1  state HALTING or RESUMING
timeout_err  out  1  sticky handshake timeout

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All outputs are registered.
- Reset values (rst_n=0, or dm_active=0 at a clk edge): state RUNNING, halt_req=0, resume_req=0, st_running=1, st_halted=0, st_resumeack=0, st_havereset=1, busy=0, timeout_err=0, counter=0.
- States: RUNNING, HALTING, HALTED, RESUMING. halt_req=(state==HALTING). resume_req=(state==RESUMING). The two are never high together.
- RUNNING:
  - hart_halted=1 (step, ebreak or external halt) → HALTED.
  - else dm_haltreq=1 → HALTING.
  - dm_resumereq is ignored.
- HALTING: halt_req is held until hart_halted=1, then → HALTED. Dropping dm_haltreq does not abort, because the core latches a halt request. Sample timing: dm_haltreq seen at edge N gives halt_req=1 after edge N; hart_halted=1 at edge M gives st_halted=1 and halt_req=0 after edge M.
- HALTED:
  - dm_resumereq=1 and dm_haltreq=0 → RESUMING, st_resumeack cleared at the same edge.
  - dm_resumereq with dm_haltreq=1 is ignored.
  - hart_halted falling without a request → RUNNING, resumeack unchanged.
- RESUMING: resume_req is held until hart_halted=0, then → RUNNING and st_resumeack=1. dm_haltreq during RESUMING is deferred: the resume completes, and from RUNNING the still-high dm_haltreq enters HALTING on the next edge.
- Counter: width $clog2(TIMEOUT_CYCLES+1).
  - Cleared on entry to HALTING or RESUMING.
  - Increments every cycle in those states and saturates at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES sets timeout_err; the state does not change and the request stays asserted.
  - timeout_clr clears timeout_err; a set in the same cycle wins.
- st_havereset: set while hart_reset=1; cleared by dm_ackhavereset; set wins if both occur in one cycle.
- hart_reset=1 forces state to RUNNING and clears halt_req, resume_req, counter and st_resumeack. This has priority over all transitions except rst_n and dm_active.
- Priority per edge: rst_n > dm_active=0 > hart_reset > FSM transitions.
- Asserting rst_n mid-handshake drops halt_req/resume_req immediately (asynchronously).

Test Plan:
- Halt: dm_haltreq=1 at cycle 2; hart_halted rises at cycle 6 → halt_req=1 cycles 3–6, then st_halted=1, busy=0, halt_req=0 at cycle 7.
- Resume: from HALTED, dm_resumereq pulse at cycle 10; hart_halted falls at cycle 13 → resume_req=1 cycles 11–13, then st_resumeack=1, st_running=1 at cycle 14.
- Resume ignored: dm_haltreq=1 and dm_resumereq pulse while HALTED → state stays HALTED, resume_req=0, st_resumeack unchanged.
- Timeout: TIMEOUT_CYCLES=4, hart never halts → timeout_err=1 after 4 cycles in HALTING, halt_req still 1; timeout_clr pulse → timeout_err=0, and it sets again only after the next entry into HALTING plus 4 cycles.
- Havereset: after reset st_havereset=1; dm_ackhavereset → 0; hart_reset and dm_ackhavereset in the same cycle → 1; hart_reset during HALTING → RUNNING, halt_req=0.
- Spontaneous halt: in RUNNING, hart_halted rises with dm_haltreq=0 → st_halted=1 next cycle, halt_req never asserted; async rst_n mid-RESUMING → resume_req=0 immediately.
